frame_buf_ctrl: RTL and testbench

//  N-buffer (3..8) frame-swap controller between video producer/consumer and sdram_mcb.

---
 rtl/frame_buf_ctrl_pkg.sv | 35 +++
 rtl/frame_buf_ctrl_if.sv | 32 +++
 rtl/frame_buf_ctrl_sync_edge.sv | 43 ++++
 rtl/frame_buf_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_frame_buf_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/frame_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_ctrl_pkg
// Purpose  : Shared encodings for the frame buffer swap controller: per-buffer
//            ownership state and the writer / reader FSM state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package frame_buf_ctrl_pkg;

  // Buffer index width; supports up to 8 buffers.
  localparam int IDX_W = 3;

  // Ownership of one frame buffer.
  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_HELD    = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LOAD = 2'd1,
    W_BUSY = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_BUSY = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_ctrl_if
// Purpose  : Burst command/completion bundle between the frame buffer
//            controller (master) and the memory controller (slave).
// Signals  : wr_load/wr_addr/wr_length -> write burst command, wr_done <- done
//            rd_load/rd_addr/rd_length -> read burst command,  rd_done <- done
// Revision : 1.0 - initial release
// ============================================================================
interface frame_buf_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_length;
  logic              wr_done;
  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_length;
  logic              rd_done;

  modport master (
    output wr_load, wr_addr, wr_length, rd_load, rd_addr, rd_length,
    input  wr_done, rd_done
  );

  modport slave (
    input  wr_load, wr_addr, wr_length, rd_load, rd_addr, rd_length,
    output wr_done, rd_done
  );
endinterface
`default_nettype wire

// File: rtl/frame_buf_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_ctrl_sync_edge
// Purpose  : Synchronise an asynchronous level and emit a registered
//            one-cycle pulse on its rising edge.
// Ports    : clk, rst     - clock, async active-high reset
//            async_in     - asynchronous level input
//            rise         - 1-cycle pulse, SYNC_STG+1 cycles after input rise
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_ctrl_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  if (SYNC_STG < 2 || SYNC_STG > 3) begin : g_stg_chk
    $error("frame_buf_ctrl_sync_edge: SYNC_STG must be 2..3");
  end

  logic [SYNC_STG-1:0] r_sync;
  logic                r_prev;
  logic                r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], async_in};
      r_prev <= r_sync[SYNC_STG-1];
      r_rise <= r_sync[SYNC_STG-1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_ctrl
// Purpose  : N-buffer (3..8) frame swap controller. Independent writer and
//            reader FSMs issue burst loads; the reader always starts on the
//            newest completed frame, dropping stale ones or repeating the
//            held one when nothing new arrived.
// Ports    : clk, rst                  - clock, async active-high reset
//            mem_rdy                   - memory ready, gates new loads
//            wr_frame_tgl/rd_frame_tgl - async frame-start levels
//            mcb                       - burst command bundle (master)
//            wr_active/rd_active       - channel busy flags
//            wr_buf_idx/rd_buf_idx     - current write / read buffer
//            frame_dropped/frame_repeated/start_err - 1-cycle status pulses
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_ctrl
  import frame_buf_ctrl_pkg::*;
#(
  parameter int NUM_BUF    = 3,
  parameter int ADDR_W     = 24,
  parameter int BASE_ADDR  = 0,
  parameter int BUF_STRIDE = 1048576,
  parameter int FRAME_LEN  = 786432,
  parameter int SYNC_STG   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rdy,
  input  logic                  wr_frame_tgl,
  input  logic                  rd_frame_tgl,
  frame_buf_ctrl_if.master      mcb,
  output logic                  wr_active,
  output logic                  rd_active,
  output logic [IDX_W-1:0]      wr_buf_idx,
  output logic [IDX_W-1:0]      rd_buf_idx,
  output logic                  frame_dropped,
  output logic                  frame_repeated,
  output logic                  start_err
);

  localparam logic [ADDR_W-1:0] c_BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(BUF_STRIDE);
  localparam logic [ADDR_W-1:0] c_LEN    = ADDR_W'(FRAME_LEN);
  localparam longint c_END = longint'(BASE_ADDR) + longint'(NUM_BUF) * longint'(BUF_STRIDE);

  if (NUM_BUF < 3 || NUM_BUF > 8) begin : g_num_buf_chk
    $error("frame_buf_ctrl: NUM_BUF must be 3..8");
  end
  if (c_END > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("frame_buf_ctrl: buffers exceed address space");
  end

  logic w_wr_edge, w_rd_edge;

  frame_buf_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_wr_sync (
    .clk(clk), .rst(rst), .async_in(wr_frame_tgl), .rise(w_wr_edge)
  );
  frame_buf_ctrl_sync_edge #(.SYNC_STG(SYNC_STG)) u_rd_sync (
    .clk(clk), .rst(rst), .async_in(rd_frame_tgl), .rise(w_rd_edge)
  );

  buf_state_t        r_buf [NUM_BUF];
  buf_state_t        w_buf_nxt [NUM_BUF];
  wr_state_t         r_wr_st, w_wr_st_nxt;
  rd_state_t         r_rd_st, w_rd_st_nxt;
  logic [IDX_W-1:0]  r_wr_idx, w_wr_idx_nxt, r_rd_idx, w_rd_idx_nxt;
  logic [IDX_W-1:0]  r_latest_idx, w_latest_idx_nxt;
  logic              r_latest_vld, w_latest_vld_nxt, r_have_held, w_have_held_nxt;
  logic              w_wr_sel, w_rd_sel, w_drop, w_rep, w_err;
  logic              r_drop, r_rep, r_err;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr, r_wr_len, r_rd_len;
  logic              w_free_hit, w_old_hit, w_latest_ready;
  logic [IDX_W-1:0]  w_free_idx, w_old_idx;

  // Priority encoders over the registered buffer state (lowest index wins).
  // "Old" = READY but not the newest completed frame.
  always_comb begin
    w_free_hit     = 1'b0;
    w_free_idx     = '0;
    w_old_hit      = 1'b0;
    w_old_idx      = '0;
    w_latest_ready = 1'b0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (r_buf[i] == BUF_FREE) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_buf[i] == BUF_READY && r_latest_idx != IDX_W'(i)) begin
        w_old_hit = 1'b1;
        w_old_idx = IDX_W'(i);
      end
      if (r_buf[i] == BUF_READY && r_latest_idx == IDX_W'(i) && r_latest_vld) begin
        w_latest_ready = 1'b1;
      end
    end
  end

  // Next state for both FSMs and the buffer table. Reader updates are applied
  // first so a writer claim on the same buffer in the same cycle takes effect.
  always_comb begin
    w_wr_st_nxt      = r_wr_st;
    w_rd_st_nxt      = r_rd_st;
    w_wr_idx_nxt     = r_wr_idx;
    w_rd_idx_nxt     = r_rd_idx;
    w_latest_idx_nxt = r_latest_idx;
    w_latest_vld_nxt = r_latest_vld;
    w_have_held_nxt  = r_have_held;
    w_buf_nxt        = r_buf;
    w_wr_sel         = 1'b0;
    w_rd_sel         = 1'b0;
    w_drop           = 1'b0;
    w_rep            = 1'b0;
    w_err            = (w_wr_edge && r_wr_st != W_IDLE) || (w_rd_edge && r_rd_st != R_IDLE);

    case (r_rd_st)
      R_IDLE: begin
        if (w_rd_edge && mem_rdy) begin
          if (w_latest_ready) begin
            // Take the newest frame; release the held one and discard stale ones.
            for (int i = 0; i < NUM_BUF; i++) begin
              if ((r_have_held && r_rd_idx == IDX_W'(i)) ||
                  (r_buf[i] == BUF_READY && r_latest_idx != IDX_W'(i)))
                w_buf_nxt[i] = BUF_FREE;
            end
            w_drop       = w_old_hit;
            w_rd_idx_nxt = r_latest_idx;
            w_rd_sel     = 1'b1;
            w_rd_st_nxt  = R_LOAD;
          end else if (r_have_held) begin
            w_rep       = 1'b1;
            w_rd_sel    = 1'b1;
            w_rd_st_nxt = R_LOAD;
          end
        end
      end
      R_LOAD: begin
        for (int i = 0; i < NUM_BUF; i++)
          if (r_rd_idx == IDX_W'(i)) w_buf_nxt[i] = BUF_HELD;
        w_have_held_nxt = 1'b1;
        w_rd_st_nxt     = R_BUSY;
      end
      R_BUSY:  if (mcb.rd_done) w_rd_st_nxt = R_IDLE;
      default: w_rd_st_nxt = R_IDLE;
    endcase

    case (r_wr_st)
      W_IDLE: begin
        // With >=3 buffers, at most one HELD and one latest, a candidate always exists.
        if (w_wr_edge && mem_rdy && (w_free_hit || w_old_hit)) begin
          if (w_free_hit) begin
            w_wr_idx_nxt = w_free_idx;
          end else begin
            w_wr_idx_nxt = w_old_idx;
            w_drop       = 1'b1;
          end
          w_wr_sel    = 1'b1;
          w_wr_st_nxt = W_LOAD;
        end
      end
      W_LOAD: begin
        for (int i = 0; i < NUM_BUF; i++)
          if (r_wr_idx == IDX_W'(i)) w_buf_nxt[i] = BUF_WRITING;
        w_wr_st_nxt = W_BUSY;
      end
      W_BUSY: begin
        if (mcb.wr_done) begin
          for (int i = 0; i < NUM_BUF; i++)
            if (r_wr_idx == IDX_W'(i)) w_buf_nxt[i] = BUF_READY;
          w_latest_idx_nxt = r_wr_idx;
          w_latest_vld_nxt = 1'b1;
          w_wr_st_nxt      = W_IDLE;
        end
      end
      default: w_wr_st_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUF; i++) r_buf[i] <= BUF_FREE;
      r_wr_st      <= W_IDLE;
      r_rd_st      <= R_IDLE;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_latest_idx <= '0;
      r_latest_vld <= 1'b0;
      r_have_held  <= 1'b0;
      r_drop       <= 1'b0;
      r_rep        <= 1'b0;
      r_err        <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_len     <= '0;
      r_rd_len     <= '0;
    end else begin
      r_buf        <= w_buf_nxt;
      r_wr_st      <= w_wr_st_nxt;
      r_rd_st      <= w_rd_st_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_latest_idx <= w_latest_idx_nxt;
      r_latest_vld <= w_latest_vld_nxt;
      r_have_held  <= w_have_held_nxt;
      r_drop       <= w_drop;
      r_rep        <= w_rep;
      r_err        <= w_err;
      // Address and length are latched at selection so they are stable from the load pulse on.
      if (w_wr_sel) begin
        r_wr_addr <= c_BASE + ADDR_W'(w_wr_idx_nxt) * c_STRIDE;
        r_wr_len  <= c_LEN;
      end
      if (w_rd_sel) begin
        r_rd_addr <= c_BASE + ADDR_W'(w_rd_idx_nxt) * c_STRIDE;
        r_rd_len  <= c_LEN;
      end
    end
  end

  assign mcb.wr_load     = (r_wr_st == W_LOAD);
  assign mcb.rd_load     = (r_rd_st == R_LOAD);
  assign mcb.wr_addr     = r_wr_addr;
  assign mcb.rd_addr     = r_rd_addr;
  assign mcb.wr_length   = r_wr_len;
  assign mcb.rd_length   = r_rd_len;
  assign wr_active       = (r_wr_st == W_BUSY);
  assign rd_active       = (r_rd_st == R_BUSY);
  assign wr_buf_idx      = r_wr_idx;
  assign rd_buf_idx      = r_rd_idx;
  assign frame_dropped   = r_drop;
  assign frame_repeated  = r_rep;
  assign start_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buf_ctrl
// Purpose  : Directed self-checking bench for frame_buf_ctrl (3 buffers,
//            24-bit addresses, stride 0x100000, frame length 0xC0000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buf_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic mem_rdy;
  logic wr_frame_tgl;
  logic rd_frame_tgl;
  logic wr_active, rd_active;
  logic [2:0] wr_buf_idx, rd_buf_idx;
  logic frame_dropped, frame_repeated, start_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [23:0] c_LEN = 24'hC0000;

  frame_buf_ctrl_if #(.ADDR_W(24)) mcb ();

  frame_buf_ctrl #(
    .NUM_BUF(3), .ADDR_W(24), .BASE_ADDR(0), .BUF_STRIDE(1048576),
    .FRAME_LEN(786432), .SYNC_STG(2)
  ) dut (
    .clk(clk), .rst(rst), .mem_rdy(mem_rdy),
    .wr_frame_tgl(wr_frame_tgl), .rd_frame_tgl(rd_frame_tgl),
    .mcb(mcb),
    .wr_active(wr_active), .rd_active(rd_active),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx),
    .frame_dropped(frame_dropped), .frame_repeated(frame_repeated),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full write frame: edge, load check, done pulse.
  task automatic do_wr(input string tag, input logic [2:0] idx, input logic [23:0] addr,
                       input logic drop);
    wr_frame_tgl = 1'b1;
    cyc(4);
    check({tag, "_load"}, {mcb.wr_load, wr_buf_idx, mcb.wr_addr, mcb.wr_length, frame_dropped},
          {1'b1, idx, addr, c_LEN, drop});
    wr_frame_tgl = 1'b0;
    cyc(1);
    check({tag, "_busy"}, {mcb.wr_load, wr_active, frame_dropped}, 3'b010);
    mcb.wr_done = 1'b1;
    cyc(1);
    mcb.wr_done = 1'b0;
    cyc(2);
  endtask

  // One full read frame: edge, load check, done pulse.
  task automatic do_rd(input string tag, input logic [2:0] idx, input logic [23:0] addr,
                       input logic drop, input logic rep);
    rd_frame_tgl = 1'b1;
    cyc(4);
    check({tag, "_load"}, {mcb.rd_load, rd_buf_idx, mcb.rd_addr, mcb.rd_length, frame_dropped, frame_repeated},
          {1'b1, idx, addr, c_LEN, drop, rep});
    rd_frame_tgl = 1'b0;
    cyc(1);
    check({tag, "_busy"}, {mcb.rd_load, rd_active, frame_dropped, frame_repeated}, 4'b0100);
    mcb.rd_done = 1'b1;
    cyc(1);
    mcb.rd_done = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst          = 1'b1;
    mem_rdy      = 1'b0;
    wr_frame_tgl = 1'b0;
    rd_frame_tgl = 1'b0;
    mcb.wr_done  = 1'b0;
    mcb.rd_done  = 1'b0;
    cyc(2);
    check("reset_flags", {mcb.wr_load, mcb.rd_load, wr_active, rd_active, wr_buf_idx, rd_buf_idx,
          frame_dropped, frame_repeated, start_err}, '0);
    check("reset_bus", {mcb.wr_addr, mcb.rd_addr, mcb.wr_length, mcb.rd_length}, '0);
    rst     = 1'b0;
    mem_rdy = 1'b1;
    cyc(2);

    // Read before any completed frame: nothing happens.
    rd_frame_tgl = 1'b1;
    cyc(4);
    check("rd_before_wr_load", {mcb.rd_load, frame_repeated}, 2'b00);
    cyc(1);
    check("rd_before_wr_active", rd_active, 1'b0);
    rd_frame_tgl = 1'b0;
    cyc(3);

    // First write: load exactly SYNC_STG+2 cycles after the input edge.
    wr_frame_tgl = 1'b1;
    cyc(3);
    check("wr1_early", mcb.wr_load, 1'b0);
    cyc(1);
    check("wr1_load", {mcb.wr_load, wr_buf_idx, mcb.wr_addr, mcb.wr_length}, {1'b1, 3'd0, 24'h000000, c_LEN});
    wr_frame_tgl = 1'b0;
    cyc(1);
    check("wr1_busy", {mcb.wr_load, wr_active}, 2'b01);
    cyc(2);

    // Frame start while writer busy: error pulse, no load.
    wr_frame_tgl = 1'b1;
    cyc(4);
    check("busy_edge_err", {start_err, mcb.wr_load, wr_active}, 3'b101);
    cyc(1);
    check("busy_edge_pulse", start_err, 1'b0);
    wr_frame_tgl = 1'b0;
    mcb.wr_done = 1'b1;
    cyc(1);
    mcb.wr_done = 1'b0;
    check("wr1_done_idle", wr_active, 1'b0);
    cyc(3);

    // Read frame 0, then write goes to buffer 1.
    do_rd("rd1", 3'd0, 24'h000000, 1'b0, 1'b0);
    do_wr("wr2", 3'd1, 24'h100000, 1'b0);
    // Newest is buffer 1; held buffer 0 released.
    do_rd("rd2", 3'd1, 24'h100000, 1'b0, 1'b0);
    // Nothing new: repeat buffer 1.
    do_rd("rd3", 3'd1, 24'h100000, 1'b0, 1'b1);

    // Frame start with memory not ready: silently dropped.
    mem_rdy = 1'b0;
    wr_frame_tgl = 1'b1;
    cyc(4);
    check("nordy_load", {mcb.wr_load, start_err}, 2'b00);
    cyc(1);
    check("nordy_idle", {wr_active, start_err}, 2'b00);
    wr_frame_tgl = 1'b0;
    cyc(3);
    mem_rdy = 1'b1;

    // Both channels busy, then reset mid-burst.
    wr_frame_tgl = 1'b1;
    rd_frame_tgl = 1'b1;
    cyc(4);
    check("both_load", {mcb.wr_load, wr_buf_idx, mcb.rd_load, rd_buf_idx, frame_repeated},
          {1'b1, 3'd0, 1'b1, 3'd1, 1'b1});
    cyc(1);
    check("both_busy", {wr_active, rd_active}, 2'b11);
    rst = 1'b1;
    wr_frame_tgl = 1'b0;
    rd_frame_tgl = 1'b0;
    cyc(1);
    check("midrst_flags", {mcb.wr_load, mcb.rd_load, wr_active, rd_active, wr_buf_idx, rd_buf_idx,
          frame_dropped, frame_repeated, start_err}, '0);
    check("midrst_bus", {mcb.wr_addr, mcb.rd_addr, mcb.wr_length, mcb.rd_length}, '0);
    cyc(1);
    rst = 1'b0;
    cyc(3);

    // Three writes fill all buffers; the fourth overwrites the oldest READY.
    do_wr("rw1", 3'd0, 24'h000000, 1'b0);
    do_wr("rw2", 3'd1, 24'h100000, 1'b0);
    do_wr("rw3", 3'd2, 24'h200000, 1'b0);
    do_wr("rw4", 3'd0, 24'h000000, 1'b1);
    // Reader takes newest (buffer 0), discarding buffers 1 and 2.
    do_rd("rr1", 3'd0, 24'h000000, 1'b1, 1'b0);
    do_wr("rw5", 3'd1, 24'h100000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
